// File: rtl/hd_class_search.sv
`default_nettype none
// ============================================================================
// Module   : hd_class_search
// Purpose  : Scans all class banks in parallel, accumulates the signed dot
//            product of each class against the query, then runs a sequential
//            argmax. Define HD_SEARCH_SAT_EN for saturating accumulators.
// Revision : 1.0 - initial release
// ============================================================================
module hd_class_search #(
    parameter int M_SIZE     = 16,
    parameter int FTWIDTH    = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int DIM_WORDS  = 6500,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mem_ready,
    output logic [ADDR_WIDTH-1:0]         read_address,
    output logic                          re,
    input  logic [M_SIZE*FTWIDTH-1:0]     class_in,
    input  logic [FTWIDTH-1:0]            query_in,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(M_SIZE)-1:0]     pred_class,
    output logic signed [ACC_WIDTH-1:0]   best_score
);

    localparam int IDX_W  = $clog2(M_SIZE);
    localparam int PROD_W = 2 * FTWIDTH;
    localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(DIM_WORDS - 1);
    localparam logic [IDX_W-1:0]      C_LAST_IDX  = IDX_W'(M_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_DRAIN  = 3'd2,
        S_ARGMAX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          acc_en_q;
    logic signed [ACC_WIDTH-1:0]   acc_q [M_SIZE];
    logic signed [ACC_WIDTH-1:0]   best_q;
    logic [IDX_W-1:0]              best_idx_q;
    logic [IDX_W-1:0]              pred_q;
    logic signed [ACC_WIDTH-1:0]   score_q;

    logic                          w_go;
    logic signed [PROD_W-1:0]      w_prod [M_SIZE];
    logic signed [ACC_WIDTH-1:0]   w_cand;
    logic                          w_take;
    logic signed [ACC_WIDTH-1:0]   w_best_d;
    logic [IDX_W-1:0]              w_best_idx_d;

    // The sum is formed wide enough to hold any product before clamping, so
    // saturation also works when the product is wider than the accumulator.
    function automatic logic signed [ACC_WIDTH-1:0] acc_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [PROD_W-1:0]    p
    );
`ifdef HD_SEARCH_SAT_EN
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] c_max;
        logic signed [SUM_W-1:0] c_min;
        c_max = {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
        c_min = {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
        s     = SUM_W'(a) + SUM_W'(p);
        if (s > c_max) begin
            acc_add = c_max[ACC_WIDTH-1:0];
        end else if (s < c_min) begin
            acc_add = c_min[ACC_WIDTH-1:0];
        end else begin
            acc_add = s[ACC_WIDTH-1:0];
        end
`else
        acc_add = a + ACC_WIDTH'(p);
`endif
    endfunction

    assign w_go = start && mem_ready;

    always_comb begin
        for (int c = 0; c < M_SIZE; c++) begin
            w_prod[c] = PROD_W'($signed(class_in[c*FTWIDTH +: FTWIDTH])) * PROD_W'($signed(query_in));
        end
    end

    // Class 0 seeds the best; later classes win only when strictly greater.
    always_comb begin
        w_cand       = acc_q[idx_q];
        w_take       = (idx_q == '0) || (w_cand > best_q);
        w_best_d     = w_take ? w_cand : best_q;
        w_best_idx_d = w_take ? idx_q  : best_idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        read_address = '0;
        re           = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_go) begin
                    state_d = S_SCAN;
                    addr_d  = '0;
                end
            end
            S_SCAN: begin
                re           = 1'b1;
                busy         = 1'b1;
                read_address = addr_q;
                addr_d       = addr_q + 1'b1;
                if (addr_q == C_LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                idx_d   = '0;
                state_d = S_ARGMAX;
            end
            S_ARGMAX: begin
                busy  = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == C_LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so accumulation trails SCAN.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_en_q   <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
            pred_q     <= '0;
            score_q    <= '0;
            for (int c = 0; c < M_SIZE; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            acc_en_q <= (state_q == S_SCAN);
            if ((state_q == S_IDLE) && w_go) begin
                for (int c = 0; c < M_SIZE; c++) begin
                    acc_q[c] <= '0;
                end
            end else if (acc_en_q) begin
                for (int c = 0; c < M_SIZE; c++) begin
                    acc_q[c] <= acc_add(acc_q[c], w_prod[c]);
                end
            end
            if (state_q == S_ARGMAX) begin
                best_q     <= w_best_d;
                best_idx_q <= w_best_idx_d;
                if (idx_q == C_LAST_IDX) begin
                    pred_q  <= w_best_idx_d;
                    score_q <= w_best_d;
                end
            end
        end
    end

    assign pred_class = pred_q;
    assign best_score = score_q;

endmodule
`default_nettype wire

// File: tb/tb_hd_class_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_hd_class_search
// Purpose  : Checks hd_class_search (32-bit and 12-bit accumulator builds)
//            against an arithmetic reference model; honours HD_SEARCH_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hd_class_search;

    localparam int M  = 16;
    localparam int FW = 8;
    localparam int AW = 13;
    localparam int D  = 8;
`ifdef HD_SEARCH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic               start;
    logic               mem_ready;
    logic [M*FW-1:0]    class_in;
    logic [FW-1:0]      query_in;
    logic [AW-1:0]      read_address, read_address_n;
    logic               re, re_n, busy, busy_n, done, done_n;
    logic [3:0]         pred_class, pred_class_n;
    logic [31:0]        best_score;
    logic [11:0]        best_score_n;

    int n_total = 0;
    int n_bad   = 0;

    byte cls [M][D];
    byte qry [D];

    hd_class_search #(.M_SIZE(M), .FTWIDTH(FW), .ADDR_WIDTH(AW), .DIM_WORDS(D), .ACC_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
        .read_address(read_address), .re(re), .class_in(class_in), .query_in(query_in),
        .busy(busy), .done(done), .pred_class(pred_class), .best_score(best_score)
    );

    hd_class_search #(.M_SIZE(M), .FTWIDTH(FW), .ADDR_WIDTH(AW), .DIM_WORDS(D), .ACC_WIDTH(12)) u_dut_n (
        .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
        .read_address(read_address_n), .re(re_n), .class_in(class_in), .query_in(query_in),
        .busy(busy_n), .done(done_n), .pred_class(pred_class_n), .best_score(best_score_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memory; junk is driven whenever no read is issued.
    always @(posedge clk) begin
        if (re) begin
            for (int c = 0; c < M; c++) class_in[c*FW +: FW] <= cls[c][int'(read_address)];
            query_in <= qry[int'(read_address)];
        end else begin
            for (int c = 0; c < M; c++) class_in[c*FW +: FW] <= FW'($urandom);
            query_in <= FW'($urandom);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: per-class dot product under w-bit wrap or clamp, then argmax.
    task automatic model(input int w, output int pc, output longint sc);
        longint m, hi, lo, acc, best;
        m  = 64'sd1 <<< w;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -(64'sd1 <<< (w - 1));
        best = 0;
        pc   = 0;
        for (int c = 0; c < M; c++) begin
            acc = 0;
            for (int d = 0; d < D; d++) begin
                acc = acc + longint'(cls[c][d]) * longint'(qry[d]);
                if (SAT) begin
                    if (acc > hi) acc = hi;
                    if (acc < lo) acc = lo;
                end else begin
                    acc = ((acc % m) + m) % m;
                    if (acc > hi) acc = acc - m;
                end
            end
            if (c == 0 || acc > best) begin
                best = acc;
                pc   = c;
            end
        end
        sc = best;
    endtask

    task automatic fill(input byte cval, input byte qval);
        for (int c = 0; c < M; c++)
            for (int d = 0; d < D; d++) cls[c][d] = cval;
        for (int d = 0; d < D; d++) qry[d] = qval;
    endtask

    task automatic set_class(input int c, input byte v);
        for (int d = 0; d < D; d++) cls[c][d] = v;
    endtask

    task automatic run_search(input string tag, input bit mid_start);
        int     lat, nre, pc;
        bit     addr_ok;
        longint sc;
        @(negedge clk);
        start     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = 1;
        nre     = 0;
        addr_ok = 1'b1;
        while (!done && lat < 100) begin
            if (re) begin
                if (int'(read_address) != nre) addr_ok = 1'b0;
                nre++;
            end
            start = (mid_start && lat == 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, D + M + 2);
        chk({tag, "_re_cycles"}, nre, D);
        chk({tag, "_addr_order"}, longint'(addr_ok), 1);
        chk({tag, "_done_n"}, longint'(done_n), 1);
        model(32, pc, sc);
        chk({tag, "_pred"}, longint'(pred_class), pc);
        chk({tag, "_score"}, longint'($signed(best_score)), sc);
        model(12, pc, sc);
        chk({tag, "_pred12"}, longint'(pred_class_n), pc);
        chk({tag, "_score12"}, longint'($signed(best_score_n)), sc);
        @(negedge clk);
        chk({tag, "_done_pulse"}, longint'(done), 0);
        chk({tag, "_addr_idle"}, longint'(read_address), 0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done || done_n) n++;
        end
    endtask

    initial begin
        int nd, bz, guard;
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        class_in  = '0;
        query_in  = '0;
        fill(8'sd0, 8'sd0);
        repeat (2) @(negedge clk);
        chk("rst_busy", longint'(busy | busy_n), 0);
        chk("rst_done", longint'(done | done_n), 0);
        chk("rst_re", longint'(re | re_n), 0);
        chk("rst_addr", longint'(read_address), 0);
        chk("rst_pred", longint'(pred_class), 0);
        chk("rst_score", longint'(best_score), 0);
        reset = 1'b0;

        start = 1'b1;
        bz    = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || busy_n) bz++;
        end
        start = 1'b0;
        chk("no_ready_busy", bz, 0);

        fill(8'sd1, 8'sd1);
        set_class(5, 8'sd2);
        run_search("basic", 1'b0);
        chk("basic_pred_const", longint'(pred_class), 5);
        chk("basic_score_const", longint'($signed(best_score)), 16);

        fill(8'sd1, 8'sd1);
        set_class(3, 8'sd3);
        set_class(9, 8'sd3);
        run_search("tie", 1'b0);
        chk("tie_pred_const", longint'(pred_class), 3);

        fill(8'sd1, -8'sd1);
        set_class(0, -8'sd3);
        run_search("neg", 1'b0);
        chk("neg_score_const", longint'($signed(best_score)), 24);

        fill(8'sd1, 8'sd1);
        set_class(5, 8'sd2);
        run_search("midstart", 1'b1);
        count_done(30, nd);
        chk("midstart_extra_done", nd, 0);

        // Abort a search while address 4 is on the bus.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(re && read_address == AW'(4)) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_reached_addr4", longint'(guard < 50), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", longint'(busy | busy_n), 0);
        chk("abort_pred", longint'(pred_class), 0);
        reset = 1'b0;
        count_done(40, nd);
        chk("abort_no_done", nd, 0);
        run_search("after_abort", 1'b0);

        fill(8'sd127, 8'sd127);
        run_search("ovf", 1'b0);
        chk("ovf_score12_const", longint'($signed(best_score_n)), SAT ? 2047 : -2040);
        chk("ovf_pred12_const", longint'(pred_class_n), 0);

        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < M; c++)
                for (int d = 0; d < D; d++) cls[c][d] = byte'($urandom);
            for (int d = 0; d < D; d++) qry[d] = byte'($urandom);
            run_search($sformatf("rand%0d", t), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
